spmv_mem_model: RTL and testbench

- Parametrised, cycle-accurate main-memory responder for spmv_pe and multi-PE benches.
- Replaces the fixed single-channel latency line with NUM_CH independent request/response channels over one shared word array.
- Per-channel: configurable latency, tag passthrough, credit-based req_stall, and a response FIFO that honours rsp_stall instead of aborting the simulation.
- Synthesizable, so it also serves as an FPGA loopback memory.

---
 rtl/spmv_mem_pkg.sv | 24 ++
 rtl/spmv_mem_rsp_chan.sv | 137 +++++++++++++
 rtl/spmv_mem_model.sv | 80 ++++++++
 tb/tb_spmv_mem_model.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_mem_pkg.sv
// Shared helpers for the spmv memory model.
// Contents: default latency and FIFO depth, a ceil-log2 function, and the
// byte-address to word-index mapping (addr >> 3, wrapped modulo array depth).
package spmv_mem_pkg;

   localparam int unsigned DEF_LATENCY    = 16;
   localparam int unsigned DEF_FIFO_DEPTH = 32;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Word index of a byte address; out-of-range indices wrap.
   function automatic logic [63:0] word_idx(input logic [63:0] addr, input logic [63:0] words);
      return (addr >> 3) % words;
   endfunction

endpackage

// File: rtl/spmv_mem_rsp_chan.sv
// One request/response channel of the memory model.
// Holds the load latency line, the response FIFO, the outstanding-load credit
// counter and the sticky protocol-error flag.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   req_ld, req_st  load / store request of this channel
//   ld_tag, ld_data tag and array read data captured on a load accept
//   rsp_stall       receiver not ready
//   req_stall       registered: channel must not issue
//   rsp_push        registered load-response valid, with rsp_tag / rsp_q
//   err             sticky protocol-violation flag
module spmv_mem_rsp_chan
   import spmv_mem_pkg::*;
#(
   parameter int unsigned TAG_W      = 3,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned LATENCY    = DEF_LATENCY,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_ld,
   input  logic              req_st,
   input  logic [TAG_W-1:0]  ld_tag,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              rsp_stall,
   output logic              req_stall,
   output logic              rsp_push,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [DATA_W-1:0] rsp_q,
   output logic              err
);

   localparam int unsigned PL_W  = TAG_W + DATA_W;
   localparam int unsigned PTR_W = clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = clog2(FIFO_DEPTH + 1);

   logic [LATENCY-1:0] line_vld;
   logic [PL_W-1:0]    line_pl  [LATENCY];
   logic [PL_W-1:0]    fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]     wptr;
   logic [PTR_W:0]     rptr;
   logic [CNT_W-1:0]   cnt;

   logic             ld_acc_c;
   logic             viol_c;
   logic             exit_vld_c;
   logic             fifo_empty_c;
   logic             pop_c;
   logic             bypass_c;
   logic             fifo_wr_c;
   logic             fifo_rd_c;
   logic [PL_W-1:0]  pop_pl_c;
   logic [CNT_W-1:0] cnt_nxt_c;

   // Accept/violation decode, FIFO control with bypass, and credit update.
   always_comb begin
      ld_acc_c     = 1'b0;
      viol_c       = 1'b0;
      exit_vld_c   = 1'b0;
      fifo_empty_c = 1'b0;
      pop_c        = 1'b0;
      bypass_c     = 1'b0;
      fifo_wr_c    = 1'b0;
      fifo_rd_c    = 1'b0;
      pop_pl_c     = '0;
      cnt_nxt_c    = cnt;

      ld_acc_c     = req_ld & ~req_st & ~req_stall;
      viol_c       = (req_ld & req_st) | ((req_ld | req_st) & req_stall);
      exit_vld_c   = line_vld[LATENCY-1];
      fifo_empty_c = (wptr == rptr);
      pop_c        = (~fifo_empty_c | exit_vld_c) & ~rsp_stall;
      // A line exit into an empty FIFO goes straight to the response register.
      bypass_c     = fifo_empty_c & exit_vld_c & ~rsp_stall;
      fifo_wr_c    = exit_vld_c & ~bypass_c;
      fifo_rd_c    = ~fifo_empty_c & ~rsp_stall;
      pop_pl_c     = fifo_empty_c ? line_pl[LATENCY-1] : fifo_mem[rptr[PTR_W-1:0]];

      case ({ld_acc_c, pop_c})
         2'b10:   cnt_nxt_c = cnt + CNT_W'(1);
         2'b01:   cnt_nxt_c = cnt - CNT_W'(1);
         default: cnt_nxt_c = cnt;
      endcase
   end

   // Latency line valid bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         line_vld <= '0;
      end else begin
         for (int unsigned i = LATENCY - 1; i > 0; i--) begin
            line_vld[i] <= line_vld[i-1];
         end
         line_vld[0] <= ld_acc_c;
      end
   end

   // Latency line payload; qualified by line_vld so no reset is needed.
   always_ff @(posedge clk) begin
      for (int unsigned i = LATENCY - 1; i > 0; i--) begin
         line_pl[i] <= line_pl[i-1];
      end
      line_pl[0] <= {ld_tag, ld_data};
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      if (fifo_wr_c) begin
         fifo_mem[wptr[PTR_W-1:0]] <= line_pl[LATENCY-1];
      end
   end

   // FIFO pointers, credit counter, error flag and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         cnt       <= '0;
         req_stall <= 1'b0;
         rsp_push  <= 1'b0;
         rsp_tag   <= '0;
         rsp_q     <= '0;
         err       <= 1'b0;
      end else begin
         if (fifo_wr_c) wptr <= wptr + (PTR_W+1)'(1);
         if (fifo_rd_c) rptr <= rptr + (PTR_W+1)'(1);
         cnt       <= cnt_nxt_c;
         req_stall <= (cnt_nxt_c >= CNT_W'(FIFO_DEPTH));
         rsp_push  <= pop_c;
         rsp_tag   <= pop_c ? pop_pl_c[PL_W-1:DATA_W] : '0;
         rsp_q     <= pop_c ? pop_pl_c[DATA_W-1:0]    : '0;
         err       <= err | viol_c;
      end
   end

endmodule

// File: rtl/spmv_mem_model.sv
// Cycle-accurate multi-channel main-memory responder.
// NUM_CH independent request/response channels share one word array; stores
// write at the accept edge (highest channel wins on a shared word), loads read
// the pre-store value at the same edge and return after LATENCY cycles.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   req_ld/req_st  per-channel load / store request
//   req_addr       per-channel byte address
//   req_d_or_tag   store data, or load tag in the low TAG_W bits
//   req_stall      registered per-channel back-pressure
//   rsp_push/rsp_tag/rsp_q  registered load response
//   rsp_stall      per-channel receiver not ready
//   err            per-channel sticky protocol-violation flag
module spmv_mem_model
   import spmv_mem_pkg::*;
#(
   parameter int unsigned NUM_CH     = 1,
   parameter int unsigned ADDR_W     = 48,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned TAG_W      = 3,
   parameter int unsigned LATENCY    = DEF_LATENCY,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned MEM_WORDS  = 65536,
   parameter string       INIT_FILE  = ""
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        req_ld,
   input  logic [NUM_CH-1:0]        req_st,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*DATA_W-1:0] req_d_or_tag,
   output logic [NUM_CH-1:0]        req_stall,
   output logic [NUM_CH-1:0]        rsp_push,
   output logic [NUM_CH*TAG_W-1:0]  rsp_tag,
   output logic [NUM_CH*DATA_W-1:0] rsp_q,
   input  logic [NUM_CH-1:0]        rsp_stall,
   output logic [NUM_CH-1:0]        err
);

   localparam int unsigned IDX_W = (clog2(MEM_WORDS) < 1) ? 1 : clog2(MEM_WORDS);

   logic [DATA_W-1:0] mem [MEM_WORDS];
   logic [IDX_W-1:0]  idx [NUM_CH];
   logic [NUM_CH-1:0] st_ok;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign idx[g]   = IDX_W'(word_idx(64'(req_addr[g*ADDR_W +: ADDR_W]), 64'(MEM_WORDS)));
      assign st_ok[g] = rst_n & req_st[g] & ~req_ld[g] & ~req_stall[g];

      spmv_mem_rsp_chan #(
         .TAG_W      (TAG_W),
         .DATA_W     (DATA_W),
         .LATENCY    (LATENCY),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .req_ld    (req_ld[g]),
         .req_st    (req_st[g]),
         .ld_tag    (req_d_or_tag[g*DATA_W +: TAG_W]),
         .ld_data   (mem[idx[g]]),
         .rsp_stall (rsp_stall[g]),
         .req_stall (req_stall[g]),
         .rsp_push  (rsp_push[g]),
         .rsp_tag   (rsp_tag[g*TAG_W +: TAG_W]),
         .rsp_q     (rsp_q[g*DATA_W +: DATA_W]),
         .err       (err[g])
      );
   end

   // Stores; later loop iterations override, so the highest channel wins.
   always_ff @(posedge clk) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
         if (st_ok[ch]) begin
            mem[idx[ch]] <= req_d_or_tag[ch*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: tb/tb_spmv_mem_model.sv
// Directed self-checking bench for spmv_mem_model.
// dut_a: 2 channels, LATENCY=4, FIFO_DEPTH=4 (timing, credit, stores, errors, reset).
// dut_b: 1 channel, LATENCY=1, FIFO_DEPTH=4 (back-to-back throughput).
module tb_spmv_mem_model;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]   a_req_ld, a_req_st, a_req_stall, a_rsp_push, a_rsp_stall, a_err;
   logic [95:0]  a_req_addr;
   logic [127:0] a_req_d, a_rsp_q;
   logic [5:0]   a_rsp_tag;

   logic        b_req_ld, b_req_st, b_req_stall, b_rsp_push, b_rsp_stall, b_err;
   logic [47:0] b_req_addr;
   logic [63:0] b_req_d, b_rsp_q;
   logic [2:0]  b_rsp_tag;

   spmv_mem_model #(
      .NUM_CH(2), .ADDR_W(48), .DATA_W(64), .TAG_W(3), .LATENCY(4),
      .FIFO_DEPTH(4), .MEM_WORDS(256), .INIT_FILE("")
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .req_ld(a_req_ld), .req_st(a_req_st),
      .req_addr(a_req_addr), .req_d_or_tag(a_req_d), .req_stall(a_req_stall),
      .rsp_push(a_rsp_push), .rsp_tag(a_rsp_tag), .rsp_q(a_rsp_q),
      .rsp_stall(a_rsp_stall), .err(a_err)
   );

   spmv_mem_model #(
      .NUM_CH(1), .ADDR_W(48), .DATA_W(64), .TAG_W(3), .LATENCY(1),
      .FIFO_DEPTH(4), .MEM_WORDS(256), .INIT_FILE("")
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .req_ld(b_req_ld), .req_st(b_req_st),
      .req_addr(b_req_addr), .req_d_or_tag(b_req_d), .req_stall(b_req_stall),
      .rsp_push(b_rsp_push), .rsp_tag(b_rsp_tag), .rsp_q(b_rsp_q),
      .rsp_stall(b_rsp_stall), .err(b_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic a_clear();
      a_req_ld   = '0;
      a_req_st   = '0;
      a_req_addr = '0;
      a_req_d    = '0;
   endtask

   task automatic a_drive(input int ch, input logic ld, input logic st,
                          input logic [47:0] addr, input logic [63:0] d);
      a_req_ld[ch]             = ld;
      a_req_st[ch]             = st;
      a_req_addr[ch*48 +: 48]  = addr;
      a_req_d[ch*64 +: 64]     = d;
   endtask

   // One-cycle request; returns at the negedge after the accept edge.
   task automatic a_pulse(input int ch, input logic ld, input logic st,
                          input logic [47:0] addr, input logic [63:0] d);
      a_drive(ch, ld, st, addr, d);
      @(negedge clk);
      a_clear();
   endtask

   // Bounded wait for the next response on a channel of dut_a, then check it.
   task automatic a_wait_rsp(input string name, input int ch,
                             input logic [63:0] exp_tag, input logic [63:0] exp_q);
      logic found;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (a_rsp_push[ch]) found = 1'b1;
      end
      chk({name, "_arrived"}, 64'(found), 64'd1);
      chk({name, "_tag"}, 64'(a_rsp_tag[ch*3 +: 3]), exp_tag);
      chk({name, "_q"}, a_rsp_q[ch*64 +: 64], exp_q);
   endtask

   initial begin
      int acc, rcv, pushes, stalls, first, last;

      rst_n = 1'b0;
      a_clear();
      a_rsp_stall = '0;
      b_req_ld = 1'b0; b_req_st = 1'b0; b_req_addr = '0; b_req_d = '0; b_rsp_stall = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_req_stall", 64'(a_req_stall), 64'd0);
      chk("rst_rsp_push", 64'(a_rsp_push), 64'd0);
      chk("rst_err", 64'(a_err), 64'd0);
      chk("rst_rsp_q", a_rsp_q[63:0], 64'd0);
      chk("rst_b_push", 64'(b_rsp_push), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single load: word 5 = 0xDEAD, load addr 40 tag 3, exact latency
      a_pulse(0, 1'b0, 1'b1, 48'd40, 64'hDEAD);
      a_pulse(0, 1'b1, 1'b0, 48'd40, 64'd3);
      chk("lat_e0", 64'(a_rsp_push[0]), 64'd0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("lat_early", 64'(a_rsp_push[0]), 64'd0);
      end
      @(negedge clk);
      chk("lat_push", 64'(a_rsp_push[0]), 64'd1);
      chk("lat_tag", 64'(a_rsp_tag[2:0]), 64'd3);
      chk("lat_q", a_rsp_q[63:0], 64'hDEAD);
      chk("lat_ch1_idle", 64'(a_rsp_push[1]), 64'd0);
      @(negedge clk);
      chk("lat_one_cycle", 64'(a_rsp_push[0]), 64'd0);
      chk("lat_q_zero", a_rsp_q[63:0], 64'd0);

      // Credit limit: preload words 16..19, stall receiver, issue while allowed
      for (int i = 0; i < 4; i++) a_pulse(0, 1'b0, 1'b1, 48'(128 + 8*i), 64'(32'h100 + i));
      a_rsp_stall[0] = 1'b1;
      acc = 0; pushes = 0;
      for (int i = 0; i < 8; i++) begin
         if (!a_req_stall[0]) begin
            a_drive(0, 1'b1, 1'b0, 48'(128 + 8*acc), 64'(acc));
            acc++;
         end else begin
            a_clear();
         end
         @(negedge clk);
         if (a_rsp_push[0]) pushes++;
      end
      a_clear();
      chk("cred_accepted", 64'(acc), 64'd4);
      chk("cred_stall_high", 64'(a_req_stall[0]), 64'd1);
      chk("cred_err", 64'(a_err), 64'd0);
      chk("cred_no_rsp_while_stalled", 64'(pushes), 64'd0);
      a_rsp_stall[0] = 1'b0;
      rcv = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (a_rsp_push[0]) begin
            chk("cred_order_tag", 64'(a_rsp_tag[2:0]), 64'(rcv));
            chk("cred_order_q", a_rsp_q[63:0], 64'(32'h100 + rcv));
            rcv++;
         end
      end
      chk("cred_rsp_count", 64'(rcv), 64'd4);
      chk("cred_stall_low", 64'(a_req_stall[0]), 64'd0);

      // Store/load on the same edge: load sees the old value
      a_pulse(0, 1'b0, 1'b1, 48'd8, 64'h55);
      a_drive(0, 1'b0, 1'b1, 48'd8, 64'h11);
      a_drive(1, 1'b1, 1'b0, 48'd8, 64'd5);
      @(negedge clk);
      a_clear();
      a_wait_rsp("rbw_old", 1, 64'd5, 64'h55);
      a_pulse(0, 1'b1, 1'b0, 48'd8, 64'd1);
      a_wait_rsp("rbw_new", 0, 64'd1, 64'h11);

      // Same-edge stores to one word: channel 1 wins
      a_drive(0, 1'b0, 1'b1, 48'd24, 64'hA);
      a_drive(1, 1'b0, 1'b1, 48'd24, 64'hB);
      @(negedge clk);
      a_clear();
      a_pulse(0, 1'b1, 1'b0, 48'd24, 64'd2);
      a_wait_rsp("st_prio", 0, 64'd2, 64'hB);

      // Violation: load and store together on channel 1
      a_pulse(1, 1'b1, 1'b1, 48'd24, 64'h77);
      pushes = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (a_rsp_push[1]) pushes++;
      end
      chk("viol_no_rsp", 64'(pushes), 64'd0);
      chk("viol_err", 64'(a_err), 64'b10);
      a_pulse(0, 1'b1, 1'b0, 48'd24, 64'd4);
      a_wait_rsp("viol_no_write", 0, 64'd4, 64'hB);
      chk("viol_err_sticky", 64'(a_err[1]), 64'd1);

      // Reset with three loads in flight
      a_drive(0, 1'b1, 1'b0, 48'd8, 64'd1);
      @(negedge clk);
      a_drive(0, 1'b1, 1'b0, 48'd8, 64'd2);
      @(negedge clk);
      a_drive(0, 1'b1, 1'b0, 48'd8, 64'd3);
      @(negedge clk);
      a_clear();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      pushes = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (a_rsp_push[0]) pushes++;
      end
      chk("rmf_no_rsp", 64'(pushes), 64'd0);
      chk("rmf_stall", 64'(a_req_stall), 64'd0);
      chk("rmf_err_cleared", 64'(a_err), 64'd0);
      a_pulse(0, 1'b1, 1'b0, 48'd8, 64'd6);
      a_wait_rsp("rmf_mem_kept", 0, 64'd6, 64'h11);
      a_pulse(1, 1'b1, 1'b0, 48'd40, 64'd7);
      a_wait_rsp("rmf_mem_kept2", 1, 64'd7, 64'hDEAD);

      // Throughput on dut_b: preload words 0..7, then 100 back-to-back loads
      for (int i = 0; i < 8; i++) begin
         b_req_st = 1'b1; b_req_addr = 48'(8*i); b_req_d = 64'(32'h1000 + i);
         @(negedge clk);
      end
      b_req_st = 1'b0;
      rcv = 0; stalls = 0; first = -1; last = -1;
      for (int k = 0; k < 110; k++) begin
         @(negedge clk);
         if (b_rsp_push) begin
            chk("tp_tag", 64'(b_rsp_tag), 64'(rcv % 8));
            chk("tp_q", b_rsp_q, 64'(32'h1000 + (rcv % 8)));
            if (first < 0) first = k;
            last = k;
            rcv++;
         end
         if (k < 100) begin
            if (b_req_stall) stalls++;
            b_req_ld = 1'b1; b_req_addr = 48'(8*(k % 8)); b_req_d = 64'(k % 8);
         end else begin
            b_req_ld = 1'b0;
         end
      end
      chk("tp_count", 64'(rcv), 64'd100);
      chk("tp_consecutive", 64'(last - first), 64'd99);
      chk("tp_first_latency", 64'(first), 64'd2);
      chk("tp_stalls", 64'(stalls), 64'd0);
      chk("tp_err", 64'(b_err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
